// File: rtl/juggle_pkg.sv
// Shared constants, types and helpers for the siteswap juggling pipeline.
// Purely declarative: no latency and no flow control.
package juggle_pkg;

    localparam int MAX_HEIGHT = 7;
    localparam int MAX_LEN    = 7;
    localparam int RING_DEPTH = 8;

    typedef logic [$clog2(MAX_HEIGHT+1)-1:0] height_t;
    typedef logic [$clog2(MAX_HEIGHT+1)-1:0] ball_id_t;
    typedef logic [$clog2(RING_DEPTH)-1:0]   slot_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_ERROR
    } seq_state_t;

    // Entry i of a flat pattern word; entry 0 sits in the low bits.
    function automatic height_t height_at(input logic [3*MAX_LEN-1:0] pat,
                                          input logic [2:0]           i);
        height_t h;
        h = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (i == 3'(k)) h = pat[3*k +: 3];
        end
        return h;
    endfunction

endpackage

// File: rtl/landing_ring.sv
// Landing schedule: one {valid, ball ID} slot per future beat, combinational read/collision, write at clk.
// No backpressure: the owner gates rd_clear/wr_en and must keep rd_slot != wr_slot.
module landing_ring
    import juggle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_all,
    input  logic [2:0] rd_slot,
    input  logic       rd_clear,
    output logic       rd_valid,
    output logic [2:0] rd_id,
    input  logic [2:0] wr_slot,
    input  logic       wr_en,
    input  logic [2:0] wr_id,
    output logic       collision
);

    logic [RING_DEPTH-1:0]      valid;
    logic [RING_DEPTH-1:0][2:0] ids;

    assign rd_valid  = valid[rd_slot];
    assign rd_id     = ids[rd_slot];
    assign collision = valid[wr_slot];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            ids   <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else begin
            if (rd_clear) valid[rd_slot] <= 1'b0;
            if (wr_en) begin
                valid[wr_slot] <= 1'b1;
                ids[wr_slot]   <= wr_id;
            end
        end
    end

endmodule

// File: rtl/siteswap_sequencer.sv
// Plays a latched siteswap beat by beat, emitting throw/catch events one cycle after each tick.
// No backpressure: every tick in RUNNING is consumed, including ticks on consecutive cycles.
module siteswap_sequencer
    import juggle_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [20:0] pattern_in,
    input  logic [2:0]  pattern_length,
    input  logic        pattern_valid_in,
    input  logic        load_in,
    input  logic        stop_in,
    input  logic        beat_tick_in,
    output logic        running_out,
    output logic        error_out,
    output logic        throw_valid_out,
    output logic [2:0]  throw_height_out,
    output logic        throw_hand_out,
    output logic [2:0]  throw_ball_out,
    output logic        catch_valid_out,
    output logic [2:0]  catch_ball_out,
    output logic [2:0]  beat_index_out,
    output logic [2:0]  ball_count_out
);

    seq_state_t  state;
    logic [20:0] pat_q;
    logic [2:0]  len_q;
    logic [2:0]  idx_q;
    logic [2:0]  ptr_q;
    logic        hand_q;

    logic [2:0] h;
    logic [2:0] wr_slot;
    logic [2:0] throw_id;
    logic [2:0] rd_id;
    logic       rd_valid;
    logic       collision;
    logic       load_ok;
    logic       load_bad;
    logic       tick_go;
    logic       fault;
    logic       commit;

    assign h        = height_at(pat_q, idx_q);
    assign wr_slot  = ptr_q + h;
    assign load_ok  = load_in && pattern_valid_in && (pattern_length != 3'd0);
    assign load_bad = load_in && !load_ok;
    assign tick_go  = (state == S_RUNNING) && beat_tick_in && !load_in && !stop_in;

    // A throw faults on collision or ID exhaustion; an empty hand faults if a ball lands on it.
    assign fault    = (h != 3'd0) ? (collision || (!rd_valid && ball_count_out == 3'd7))
                                  : rd_valid;
    assign commit   = tick_go && !fault;
    assign throw_id = rd_valid ? rd_id : ball_count_out;

    landing_ring u_ring (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .clear_all (load_ok),
        .rd_slot   (ptr_q),
        .rd_clear  (commit),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .wr_slot   (wr_slot),
        .wr_en     (commit && (h != 3'd0)),
        .wr_id     (throw_id),
        .collision (collision)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= S_IDLE;
            pat_q            <= '0;
            len_q            <= '0;
            idx_q            <= '0;
            ptr_q            <= '0;
            hand_q           <= 1'b0;
            running_out      <= 1'b0;
            error_out        <= 1'b0;
            throw_valid_out  <= 1'b0;
            throw_height_out <= '0;
            throw_hand_out   <= 1'b0;
            throw_ball_out   <= '0;
            catch_valid_out  <= 1'b0;
            catch_ball_out   <= '0;
            beat_index_out   <= '0;
            ball_count_out   <= '0;
        end else begin
            throw_valid_out  <= 1'b0;
            throw_height_out <= '0;
            throw_hand_out   <= 1'b0;
            throw_ball_out   <= '0;
            catch_valid_out  <= 1'b0;
            catch_ball_out   <= '0;
            beat_index_out   <= '0;

            if (load_ok) begin
                state          <= S_RUNNING;
                running_out    <= 1'b1;
                error_out      <= 1'b0;
                pat_q          <= pattern_in;
                len_q          <= pattern_length;
                idx_q          <= '0;
                ptr_q          <= '0;
                hand_q         <= 1'b0;
                ball_count_out <= '0;
            end else if (load_bad) begin
                state       <= S_IDLE;
                running_out <= 1'b0;
                error_out   <= 1'b1;
            end else if (stop_in) begin
                state       <= S_IDLE;
                running_out <= 1'b0;
                error_out   <= 1'b0;
            end else if (tick_go) begin
                if (fault) begin
                    state       <= S_ERROR;
                    running_out <= 1'b0;
                    error_out   <= 1'b1;
                end else begin
                    throw_valid_out  <= 1'b1;
                    throw_height_out <= h;
                    throw_hand_out   <= hand_q;
                    throw_ball_out   <= (h != 3'd0) ? throw_id : 3'd0;
                    catch_valid_out  <= rd_valid;
                    catch_ball_out   <= rd_valid ? rd_id : 3'd0;
                    beat_index_out   <= idx_q;
                    if (h != 3'd0 && !rd_valid) ball_count_out <= ball_count_out + 3'd1;
                    ptr_q  <= ptr_q + 3'd1;
                    idx_q  <= (idx_q == len_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
                    hand_q <= ~hand_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_siteswap_sequencer.sv
// Self-checking bench: an absolute-beat-time landing model predicts every output word of the sequencer.
module tb_siteswap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n_in;
    logic [20:0] pattern_in;
    logic [2:0]  pattern_length;
    logic        pattern_valid_in;
    logic        load_in;
    logic        stop_in;
    logic        beat_tick_in;
    logic        running_out;
    logic        error_out;
    logic        throw_valid_out;
    logic [2:0]  throw_height_out;
    logic        throw_hand_out;
    logic [2:0]  throw_ball_out;
    logic        catch_valid_out;
    logic [2:0]  catch_ball_out;
    logic [2:0]  beat_index_out;
    logic [2:0]  ball_count_out;

    always #5 clk = ~clk;

    siteswap_sequencer dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n_in),
        .pattern_in       (pattern_in),
        .pattern_length   (pattern_length),
        .pattern_valid_in (pattern_valid_in),
        .load_in          (load_in),
        .stop_in          (stop_in),
        .beat_tick_in     (beat_tick_in),
        .running_out      (running_out),
        .error_out        (error_out),
        .throw_valid_out  (throw_valid_out),
        .throw_height_out (throw_height_out),
        .throw_hand_out   (throw_hand_out),
        .throw_ball_out   (throw_ball_out),
        .catch_valid_out  (catch_valid_out),
        .catch_ball_out   (catch_ball_out),
        .beat_index_out   (beat_index_out),
        .ball_count_out   (ball_count_out)
    );

    // {tv, height, hand, ball, cv, cball, index, count, running, error}
    typedef logic [19:0] vec_t;

    int total = 0;
    int bad   = 0;

    // Model: land[t] holds the ball landing at absolute beat t since load, -1 if none.
    int m_pat[7];
    int m_len;
    bit m_run;
    bit m_err;
    int m_cnt;
    int m_t;
    int m_idx;
    int m_hand;
    int land[256];

    function automatic vec_t observe();
        return {throw_valid_out, throw_height_out, throw_hand_out, throw_ball_out,
                catch_valid_out, catch_ball_out, beat_index_out, ball_count_out,
                running_out, error_out};
    endfunction

    function automatic vec_t status_vec();
        vec_t e;
        e      = '0;
        e[4:2] = 3'(m_cnt);
        e[1]   = m_run;
        e[0]   = m_err;
        return e;
    endfunction

    task automatic model_beat(output vec_t e);
        int hh, lid, id;
        e = '0;
        if (m_run) begin
            hh  = m_pat[m_idx];
            lid = land[m_t];
            if ((hh > 0 && (land[m_t+hh] >= 0 || (lid < 0 && m_cnt == 7))) || (hh == 0 && lid >= 0)) begin
                m_run = 0;
                m_err = 1;
            end else begin
                land[m_t] = -1;
                id = 0;
                if (hh > 0) begin
                    if (lid >= 0) id = lid;
                    else begin
                        id = m_cnt;
                        m_cnt++;
                    end
                    land[m_t+hh] = id;
                end
                e[19]    = 1'b1;
                e[18:16] = 3'(hh);
                e[15]    = m_hand[0];
                e[14:12] = 3'(id);
                e[11]    = (lid >= 0);
                e[10:8]  = (lid >= 0) ? 3'(lid) : 3'd0;
                e[7:5]   = 3'(m_idx);
                m_t++;
                m_idx  = (m_idx == m_len - 1) ? 0 : m_idx + 1;
                m_hand = m_hand ^ 1;
            end
        end
        e[4:2] = 3'(m_cnt);
        e[1]   = m_run;
        e[0]   = m_err;
    endtask

    task automatic beat(output vec_t o, output vec_t e);
        beat_tick_in = 1'b1;
        @(posedge clk);
        #1;
        beat_tick_in = 1'b0;
        model_beat(e);
        o = observe();
        if (e[19] && e[18:16] == 3'd0) o[14:12] = 3'd0;
        if (e[19] && !e[11]) o[10:8] = 3'd0;
    endtask

    task automatic load(input int pat[7], input int len, input bit vld, input bit tick,
                        output vec_t o, output vec_t e);
        for (int k = 0; k < 7; k++)
            pattern_in[3*k +: 3] = (k < len) ? 3'(pat[k]) : 3'($urandom_range(0, 7));
        pattern_length   = 3'(len);
        pattern_valid_in = vld;
        load_in          = 1'b1;
        beat_tick_in     = tick;
        @(posedge clk);
        #1;
        load_in          = 1'b0;
        beat_tick_in     = 1'b0;
        pattern_in       = 21'($urandom);
        pattern_length   = 3'($urandom_range(0, 7));
        pattern_valid_in = 1'($urandom);
        if (vld && len != 0) begin
            m_pat  = pat;
            m_len  = len;
            m_run  = 1;
            m_err  = 0;
            m_cnt  = 0;
            m_t    = 0;
            m_idx  = 0;
            m_hand = 0;
            foreach (land[i]) land[i] = -1;
        end else begin
            m_run = 0;
            m_err = 1;
        end
        e = status_vec();
        o = observe();
    endtask

    task automatic do_stop(output vec_t o, output vec_t e);
        stop_in = 1'b1;
        @(posedge clk);
        #1;
        stop_in = 1'b0;
        m_run = 0;
        m_err = 0;
        e = status_vec();
        o = observe();
    endtask

    task automatic test_pattern(input string name, input int pat[7], input int len,
                                input int nbeats, input int exp_balls[12]);
        vec_t o, e;
        load(pat, len, 1'b1, 1'b0, o, e);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL %s load: got %h want %h", name, o, e);
        end
        for (int b = 0; b < nbeats; b++) begin
            beat(o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL %s beat %0d: got %h want %h", name, b, o, e);
            end
            if (b < 12 && exp_balls[b] >= 0) begin
                total++;
                if (throw_ball_out !== 3'(exp_balls[b])) begin
                    bad++;
                    $display("FAIL %s ball beat %0d: got %0d want %0d", name, b, throw_ball_out, exp_balls[b]);
                end
            end
        end
    endtask

    task automatic test_reset();
        vec_t o;
        rst_n_in         = 1'b0;
        pattern_in       = '0;
        pattern_length   = '0;
        pattern_valid_in = 1'b0;
        load_in          = 1'b0;
        stop_in          = 1'b0;
        beat_tick_in     = 1'b0;
        m_run = 0; m_err = 0; m_cnt = 0; m_t = 0; m_idx = 0; m_hand = 0; m_len = 1;
        foreach (land[i]) land[i] = -1;
        foreach (m_pat[i]) m_pat[i] = 0;
        #12;
        o = observe();
        total++;
        if (o !== 20'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", o);
        end
        @(posedge clk);
        #1;
        rst_n_in = 1'b1;
    endtask

    task automatic test_fixed();
        int p[7];
        int eb[12];
        p  = '{3, 0, 0, 0, 0, 0, 0};
        eb = '{0, 1, 2, 0, 1, 2, 0, -1, -1, -1, -1, -1};
        test_pattern("p3", p, 1, 7, eb);
        p  = '{4, 4, 1, 0, 0, 0, 0};
        eb = '{0, 1, 2, 2, 0, 1, 1, 2, 0, -1, -1, -1};
        test_pattern("p441", p, 3, 9, eb);
        p  = '{4, 0, 0, 0, 0, 0, 0};
        eb = '{-1, -1, -1, -1, 0, -1, -1, -1, -1, -1, -1, -1};
        test_pattern("p40", p, 2, 6, eb);
        p  = '{1, 2, 0, 0, 0, 0, 0};
        eb = '{0, 0, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        test_pattern("p12", p, 2, 4, eb);
    endtask

    task automatic test_invalid_load();
        vec_t o, e;
        int p[7];
        p = '{3, 0, 0, 0, 0, 0, 0};
        load(p, 1, 1'b0, 1'b0, o, e);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL bad_load: got %h want %h", o, e);
        end
        beat(o, e);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL idle_tick: got %h want %h", o, e);
        end
        load(p, 1, 1'b1, 1'b1, o, e);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL load_with_tick: got %h want %h", o, e);
        end
        for (int b = 0; b < 4; b++) begin
            beat(o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL after_load_tick beat %0d: got %h want %h", b, o, e);
            end
        end
        load(p, 0, 1'b1, 1'b0, o, e);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL zero_len_load: got %h want %h", o, e);
        end
    endtask

    task automatic test_async_reset();
        vec_t o, e;
        int p[7];
        p = '{4, 4, 1, 0, 0, 0, 0};
        load(p, 3, 1'b1, 1'b0, o, e);
        for (int b = 0; b < 4; b++) beat(o, e);
        #2;
        rst_n_in = 1'b0;
        #1;
        o = observe();
        total++;
        if (o !== 20'd0) begin
            bad++;
            $display("FAIL async_reset: got %h want 0", o);
        end
        m_run = 0; m_err = 0; m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n_in = 1'b1;
        for (int b = 0; b < 3; b++) begin
            beat(o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL post_reset_tick %0d: got %h want %h", b, o, e);
            end
        end
    endtask

    task automatic test_random();
        vec_t o, e;
        int vp[9][7];
        int vl[9];
        int p[7];
        int len, sel, nb, gap;
        bit vld;
        vp[0] = '{3, 0, 0, 0, 0, 0, 0}; vl[0] = 1;
        vp[1] = '{4, 4, 1, 0, 0, 0, 0}; vl[1] = 3;
        vp[2] = '{5, 3, 1, 0, 0, 0, 0}; vl[2] = 3;
        vp[3] = '{5, 1, 0, 0, 0, 0, 0}; vl[3] = 2;
        vp[4] = '{4, 0, 0, 0, 0, 0, 0}; vl[4] = 2;
        vp[5] = '{4, 2, 3, 0, 0, 0, 0}; vl[5] = 3;
        vp[6] = '{5, 2, 5, 1, 2, 0, 0}; vl[6] = 5;
        vp[7] = '{7, 0, 0, 0, 0, 0, 0}; vl[7] = 1;
        vp[8] = '{7, 1, 1, 0, 0, 0, 0}; vl[8] = 3;
        for (int run = 0; run < 30; run++) begin
            if ($urandom_range(0, 1) == 1) begin
                sel = $urandom_range(0, 8);
                p   = vp[sel];
                len = vl[sel];
            end else begin
                len = $urandom_range(1, 7);
                foreach (p[i]) p[i] = $urandom_range(0, 7);
            end
            vld = ($urandom_range(0, 9) != 0);
            load(p, len, vld, 1'($urandom), o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rnd %0d load: got %h want %h", run, o, e);
            end
            nb = $urandom_range(5, 40);
            for (int b = 0; b < nb; b++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    e = status_vec();
                    o = observe();
                    total++;
                    if (o !== e) begin
                        bad++;
                        $display("FAIL rnd %0d gap %0d: got %h want %h", run, b, o, e);
                    end
                end
                if ($urandom_range(0, 39) == 0) begin
                    do_stop(o, e);
                    total++;
                    if (o !== e) begin
                        bad++;
                        $display("FAIL rnd %0d stop: got %h want %h", run, o, e);
                    end
                end
                beat(o, e);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL rnd %0d beat %0d: got %h want %h", run, b, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_invalid_load();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/siteswap_sequencer.md
Name: siteswap_sequencer

Overview:
Consumes a pattern plus the combinational validity verdict from the pattern validator and plays the pattern out beat by beat. On each beat tick it emits one throw event: height, hand and ball ID. It also emits the catch event for the ball landing on that beat. A landing-schedule ring buffer assigns persistent ball IDs. Sits between the validator and the animation/renderer logic that draws balls in flight.

Parameters:
MAX_HEIGHT, 7, largest throw value; also maximum pattern length and maximum ball count
RING_DEPTH, 8, landing-schedule slots (power of two, > MAX_HEIGHT)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
pattern_in  input  7x3  throw heights, entry 0 first
pattern_length  input  3  number of used entries (1..7)
pattern_valid_in  input  1  validator verdict for pattern_in/pattern_length
load_in  input  1  one-cycle request to latch pattern and start
stop_in  input  1  one-cycle request to halt and return to idle
beat_tick_in  input  1  one-cycle pulse per juggling beat
running_out  output  1  sequencer in RUNNING state
error_out  output  1  sticky fault flag
throw_valid_out  output  1  one-cycle pulse: throw event this cycle
throw_height_out  output  3  height of current throw (0 = empty hand)
throw_hand_out  output  1  0 = right, 1 = left
throw_ball_out  output  3  ball ID thrown (meaningful only when throw_height_out > 0)
catch_valid_out  output  1  one-cycle pulse: a ball lands this beat
catch_ball_out  output  3  ID of the landing ball
beat_index_out  output  3  pattern index of current throw
ball_count_out  output  3  number of ball IDs allocated since load

Behaviour:
- Reset (async, rst_n_in low): state IDLE. All outputs 0. Ring slots invalid. Pointers, index and hand cleared.
- States: IDLE, RUNNING, ERROR.
- IDLE + load_in + pattern_valid_in + pattern_length != 0:
  - latch pattern and length into internal registers; later input changes are ignored;
  - clear ring, ptr = 0, idx = 0, hand = 0 (right), ball_count = 0, error_out = 0;
  - go to RUNNING.
- load_in with pattern_valid_in = 0 or pattern_length = 0 (any state): set error_out, go to IDLE.
- load_in with a valid pattern in RUNNING or ERROR: restart exactly as from IDLE.
- stop_in (any state): go to IDLE and clear error_out. load_in has priority over stop_in in the same cycle.
- beat_tick_in in RUNNING (load_in not asserted the same cycle), with h = pattern[idx]:
  - landing = ring[ptr]. If valid: catch_valid_out = 1, catch_ball_out = its ID. Clear ring[ptr].
  - h > 0 and landing valid: the thrown ball = landing ID.
  - h > 0 and no landing: allocate new ID = ball_count, then ball_count++. If ball_count is already 7, go to ERROR instead.
  - h > 0: write the thrown ID into ring[(ptr + h) mod 8]. If that slot is already valid (collision), go to ERROR; the ring is not written.
  - h = 0 and landing valid: go to ERROR (ball dropped).
  - throw_valid_out = 1 with height, hand, ball and beat_index = idx.
  - ptr = ptr + 1 (mod 8). idx = idx + 1, wrapping to 0 at pattern_length - 1. hand toggles.
- Since h <= 7 < RING_DEPTH, the read slot and the write slot never coincide within one beat.
- Latency: all event outputs are registered and valid in the cycle after beat_tick_in, for one cycle only. They are 0 otherwise.
- beat_tick_in is ignored in IDLE and ERROR. Ticks on consecutive cycles must each be processed.
- ERROR: sets error_out; the offending beat produces no throw/catch pulse; running_out = 0. Exit only via load_in or stop_in.
- running_out = 1 exactly in RUNNING.

Decomposition:
- Shared package juggle_pkg: MAX_HEIGHT, MAX_LEN, RING_DEPTH constants; height_t (3-bit) and ball_id_t (3-bit) typedefs; seq_state_t enum.
- Sub-module landing_ring: 8-entry {valid, ID} array with one clear-read port at ptr and one write port at ptr + h. It reports a collision flag combinationally.

Test Plan:
- Pattern "3", length 1, 7 ticks -> balls 0,1,2,0,1,2,0. Hands R,L,R,L,... catch_valid first at beat 3 with ball 0. ball_count_out = 3.
- Pattern "441", length 3, 9 ticks -> heights 4,4,1,4,4,1,4,4,1 and balls 0,1,2,2,0,1,1,2,0. Catches begin at beat 3 (ball 2). ball_count_out = 3.
- Pattern "40", length 2, 6 ticks -> beat 1 and beat 3 give throw height 0 with no catch. Beat 4 catches and rethrows ball 0. ball_count_out = 2.
- Pattern "12" forced with pattern_valid_in = 1 -> beat 2 collides on slot 3. error_out = 1, running_out = 0, and no throw pulse on that beat.
- load_in with pattern_valid_in = 0 -> stays IDLE with error_out = 1. Then load_in and beat_tick_in in the same cycle with a valid "3" -> restart, tick ignored, no throw pulse.
- rst_n_in low mid-run for "441" -> all outputs 0 immediately (asynchronous). After release, ticks produce nothing until load_in.
